// File: rtl/tbird_light_sequencer.sv
// rtl/tbird_light_sequencer.sv - Thunderbird tail-light turn/hazard sequencer
//
// Sequences three lamps per side outward for a turn request, or lights all
// six lamps together for hazard, with one prescaled tick per lamp step.
// Optional brake overlay: define TBIRD_BRAKE_EN.
//
// Parameters:
//   TICK_DIV  clocks per lamp step (2..255)
// Ports:
//   Clock          system clock, rising edge
//   Clear          asynchronous active-low reset
//   Left, Right    turn requests (synchronous levels)
//   Hazard         hazard request (synchronous level)
//   Brake          brake request, only used with TBIRD_BRAKE_EN
//   LA, LB, LC     left lamps, inner to outer
//   RA, RB, RC     right lamps, inner to outer
//   Busy           high whenever the sequencer is not idle

module tbird_light_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Left,
    input  logic Right,
    input  logic Hazard,
    input  logic Brake,
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC,
    output logic Busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HZ   = 3'd7
    } state_t;

    localparam logic [7:0] TICK_MAX = 8'(TICK_DIV - 1);

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       tick;
    logic [5:0] lamps_nxt;   // {LA, LB, LC, RA, RB, RC}

    assign tick = (cnt == TICK_MAX);

    // Next state and prescaler. IDLE reacts every clock; turn steps wait for
    // the tick, except that hazard preempts a turn immediately and restarts
    // the prescaler so the hazard flash gets a full step.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (Hazard || (Left && Right)) begin
                    nxt = HZ;
                end else if (Left) begin
                    nxt = L1;
                end else if (Right) begin
                    nxt = R1;
                end
            end
            L1, L2, L3, R1, R2, R3: begin
                if (Hazard) begin
                    nxt     = HZ;
                    cnt_nxt = 8'd0;
                end else if (tick) begin
                    cnt_nxt = 8'd0;
                    case (state)
                        L1:      nxt = L2;
                        L2:      nxt = L3;
                        R1:      nxt = R2;
                        R2:      nxt = R3;
                        default: nxt = IDLE;
                    endcase
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HZ: begin
                if (tick) begin
                    nxt     = IDLE;
                    cnt_nxt = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                nxt     = IDLE;
                cnt_nxt = 8'd0;
            end
        endcase
    end

    // Lamp decode from the next state so lamps change on the same edge.
    always_comb begin
        lamps_nxt = 6'b000_000;
        case (nxt)
            L1:      lamps_nxt = 6'b100_000;
            L2:      lamps_nxt = 6'b110_000;
            L3:      lamps_nxt = 6'b111_000;
            R1:      lamps_nxt = 6'b000_100;
            R2:      lamps_nxt = 6'b000_110;
            R3:      lamps_nxt = 6'b000_111;
            HZ:      lamps_nxt = 6'b111_111;
            default: lamps_nxt = 6'b000_000;
        endcase
`ifdef TBIRD_BRAKE_EN
        // Brake lights every side that is not sequencing; hazard already
        // has everything on.
        if (Brake) begin
            case (nxt)
                IDLE:         lamps_nxt = 6'b111_111;
                L1, L2, L3:   lamps_nxt[2:0] = 3'b111;
                R1, R2, R3:   lamps_nxt[5:3] = 3'b111;
                default:      lamps_nxt = lamps_nxt;
            endcase
        end
`endif
    end

`ifndef TBIRD_BRAKE_EN
    logic unused_brake;
    assign unused_brake = Brake;
`endif

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
            cnt   <= 8'd0;
            {LA, LB, LC, RA, RB, RC} <= 6'b000_000;
            Busy  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            {LA, LB, LC, RA, RB, RC} <= lamps_nxt;
            Busy  <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// tb/tb_tbird_light_sequencer.sv - self-checking bench for tbird_light_sequencer

module tb_tbird_light_sequencer;

    localparam int TD = 4;

    logic Clock;
    logic Clear;
    logic Left, Right, Hazard, Brake;
    logic LA, LB, LC, RA, RB, RC, Busy;

    int checks;
    int failures;

    // Reference: kind 0 idle, 1 left turn, 2 right turn, 3 hazard;
    // t = clocks elapsed since the sequence started.
    int   m_kind;
    int   m_t;
    logic m_brake;

    tbird_light_sequencer #(.TICK_DIV(TD)) dut (
        .Clock  (Clock),
        .Clear  (Clear),
        .Left   (Left),
        .Right  (Right),
        .Hazard (Hazard),
        .Brake  (Brake),
        .LA     (LA),
        .LB     (LB),
        .LC     (LC),
        .RA     (RA),
        .RB     (RB),
        .RC     (RC),
        .Busy   (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [6:0] observed();
        return {LA, LB, LC, RA, RB, RC, Busy};
    endfunction

    task automatic model_reset();
        m_kind  = 0;
        m_t     = 0;
        m_brake = 1'b0;
    endtask

    task automatic model_update();
        m_brake = Brake;
        case (m_kind)
            0: begin
                m_t = 0;
                if (Hazard || (Left && Right)) m_kind = 3;
                else if (Left)                 m_kind = 1;
                else if (Right)                m_kind = 2;
            end
            1, 2: begin
                if (Hazard) begin
                    m_kind = 3;
                    m_t    = 0;
                end else begin
                    m_t = m_t + 1;
                    if (m_t == 3 * TD) begin
                        m_kind = 0;
                        m_t    = 0;
                    end
                end
            end
            default: begin
                m_t = m_t + 1;
                if (m_t == TD) begin
                    m_kind = 0;
                    m_t    = 0;
                end
            end
        endcase
    endtask

    function automatic logic [6:0] model_out();
        logic [2:0] left_l, right_l;
        int n;
        left_l  = 3'b000;
        right_l = 3'b000;
        n = m_t / TD + 1;
        if (m_kind == 1) left_l  = {n >= 1, n >= 2, n >= 3};
        if (m_kind == 2) right_l = {n >= 1, n >= 2, n >= 3};
        if (m_kind == 3) begin
            left_l  = 3'b111;
            right_l = 3'b111;
        end
`ifdef TBIRD_BRAKE_EN
        if (m_brake) begin
            if (m_kind == 0 || m_kind == 2) left_l  = 3'b111;
            if (m_kind == 0 || m_kind == 1) right_l = 3'b111;
        end
`endif
        return {left_l, right_l, m_kind != 0};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge Clock);
        model_update();
        #1;
        check(tag, observed(), model_out());
    endtask

    // Called 1 time unit after a rising edge: pulses Clear low between edges.
    task automatic async_clear(input string tag);
        #2 Clear = 1'b0;
        model_reset();
        #1 check(tag, observed(), 7'b000_000_0);
        #2 Clear = 1'b1;
    endtask

    task automatic set_in(input logic l, input logic r, input logic h, input logic b);
        Left = l; Right = r; Hazard = h; Brake = b;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        set_in(0, 0, 0, 0);
        Clear = 1'b0;

        // Reset state
        #1 check("reset", observed(), 7'b000_000_0);
        #11 Clear = 1'b1;

        // Left held: LA @1, LA+LB @5, all three @9, off @13, LA again @14
        set_in(1, 0, 0, 0);
        for (int e = 1; e <= 14; e++) begin
            step("left_held");
            if (e == 1)  check("left_e1",  observed(), 7'b100_000_1);
            if (e == 5)  check("left_e5",  observed(), 7'b110_000_1);
            if (e == 9)  check("left_e9",  observed(), 7'b111_000_1);
            if (e == 13) check("left_e13", observed(), 7'b000_000_0);
            if (e == 14) check("left_e14", observed(), 7'b100_000_1);
        end
        set_in(0, 0, 0, 0);
        while (m_kind != 0) step("drain");
        step("idle");

        // One-clock Left pulse runs the full 12-clock sequence
        set_in(1, 0, 0, 0);
        step("pulse_e1");
        set_in(0, 1, 0, 0);   // opposite request must be ignored mid-turn
        for (int e = 2; e <= 13; e++) begin
            step("pulse");
            if (e == 12) check("pulse_e12", observed(), 7'b111_000_1);
            if (e == 13) check("pulse_e13", observed(), 7'b000_000_0);
        end
        set_in(0, 0, 0, 0);
        step("idle2");

        // Hazard raised during L2
        set_in(1, 0, 0, 0);
        for (int e = 1; e <= 6; e++) step("to_l2");
        check("in_l2", observed(), 7'b110_000_1);
        set_in(0, 0, 1, 0);
        step("hz_enter");
        check("hz_all_on", observed(), 7'b111_111_1);
        for (int e = 0; e < 3; e++) step("hz_hold");
        step("hz_off");
        check("hz_off_after_4", observed(), 7'b000_000_0);
        step("hz_reenter");
        check("hz_blink", observed(), 7'b111_111_1);
        set_in(0, 0, 0, 0);
        while (m_kind != 0) step("hz_drain");
        step("hz_idle");
        check("hz_dropped_idle", observed(), 7'b000_000_0);

        // Left and Right together from IDLE
        set_in(1, 1, 0, 0);
        step("lr_hz");
        check("lr_both_hz", observed(), 7'b111_111_1);
        set_in(0, 0, 0, 0);
        while (m_kind != 0) step("lr_drain");

        // Async Clear mid-R2, held Right restarts at R1
        set_in(0, 1, 0, 0);
        for (int e = 1; e <= 6; e++) step("to_r2");
        check("in_r2", observed(), 7'b000_110_1);
        async_clear("clear_mid_r2");
        step("restart_r1");
        check("restart_r1_const", observed(), 7'b000_100_1);
        set_in(0, 0, 0, 0);
        while (m_kind != 0) step("r_drain");

        // Brake with no request (overlay only when the macro is defined)
        set_in(0, 0, 0, 1);
        step("brake_idle");
`ifdef TBIRD_BRAKE_EN
        check("brake_idle_const", observed(), 7'b111_111_0);
`else
        check("brake_idle_const", observed(), 7'b000_000_0);
`endif
        set_in(0, 0, 0, 0);
        step("brake_off");

        // Randomized traffic against the reference
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            step("random");
            if ($urandom_range(0, 63) == 0) async_clear("random_clear");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
